// File: rtl/board_progress_if.sv
// board_progress_if: per-frame player positions in, board progress counts and match status out
interface board_progress_if;
  logic        vsync_in;
  logic [11:0] xpos_R;
  logic [11:0] xpos_L;
  logic        priority_L;
  logic        restart;
  logic [4:0]  board_controller;
  logic [4:0]  board_controller_L;
  logic        board_change;
  logic        respawn;
  logic [1:0]  winner;
  modport master (
    output vsync_in, xpos_R, xpos_L, priority_L, restart,
    input  board_controller, board_controller_L, board_change, respawn, winner
  );
  modport slave (
    input  vsync_in, xpos_R, xpos_L, priority_L, restart,
    output board_controller, board_controller_L, board_change, respawn, winner
  );
endinterface

// File: rtl/board_progress.sv
// board_progress: steps the board progress counts when the priority player leaves the screen
module board_progress #(
  parameter int EDGE_LEFT   = 8,
  parameter int EDGE_RIGHT  = 1016,
  parameter int HOLD_FRAMES = 60,
  parameter int MAX_STEP    = 2
) (
  input logic       clk,
  input logic       reset,
  board_progress_if.slave bus
);
  typedef enum logic [1:0] {PLAY, HOLD, WIN_R, WIN_L} state_t;
  state_t     r_state;
  logic       r_vsync_d;
  logic [4:0] r_bc;
  logic [4:0] r_bcl;
  logic       r_change;
  logic       r_respawn;
  logic [1:0] r_winner;
  logic [7:0] r_hold_cnt;
  logic       w_tick;
  logic       w_exit_r;
  logic       w_exit_l;
  assign w_tick   = bus.vsync_in & ~r_vsync_d;
  assign w_exit_r = ~bus.priority_L & (bus.xpos_R <= 12'(EDGE_LEFT));
  assign w_exit_l = bus.priority_L & (bus.xpos_L >= 12'(EDGE_RIGHT));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PLAY;
      r_vsync_d  <= 1'b0;
      r_bc       <= '0;
      r_bcl      <= '0;
      r_change   <= 1'b0;
      r_respawn  <= 1'b0;
      r_winner   <= 2'b00;
      r_hold_cnt <= '0;
    end else begin
      r_vsync_d <= bus.vsync_in;
      r_change  <= 1'b0;
      case (r_state)
        PLAY: begin
          if (w_tick && w_exit_r) begin
            if (r_bcl != 5'd0 || r_bc < 5'(MAX_STEP)) begin
              r_bcl      <= (r_bcl != 5'd0) ? r_bcl - 5'd1 : r_bcl;
              r_bc       <= (r_bcl != 5'd0) ? r_bc : r_bc + 5'd1;
              r_change   <= 1'b1;
              r_respawn  <= 1'b1;
              r_hold_cnt <= '0;
              r_state    <= HOLD;
            end else begin
              r_winner <= 2'b01;
              r_state  <= WIN_R;
            end
          end else if (w_tick && w_exit_l) begin
            if (r_bc != 5'd0 || r_bcl < 5'(MAX_STEP)) begin
              r_bc       <= (r_bc != 5'd0) ? r_bc - 5'd1 : r_bc;
              r_bcl      <= (r_bc != 5'd0) ? r_bcl : r_bcl + 5'd1;
              r_change   <= 1'b1;
              r_respawn  <= 1'b1;
              r_hold_cnt <= '0;
              r_state    <= HOLD;
            end else begin
              r_winner <= 2'b10;
              r_state  <= WIN_L;
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            if (r_hold_cnt == 8'(HOLD_FRAMES - 1)) begin
              r_respawn <= 1'b0;
              r_state   <= PLAY;
            end else begin
              r_hold_cnt <= r_hold_cnt + 8'd1;
            end
          end
        end
        WIN_R, WIN_L: begin
          if (bus.restart) begin
            r_bc     <= '0;
            r_bcl    <= '0;
            r_winner <= 2'b00;
            r_state  <= PLAY;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end
  assign bus.board_controller   = r_bc;
  assign bus.board_controller_L = r_bcl;
  assign bus.board_change       = r_change;
  assign bus.respawn            = r_respawn;
  assign bus.winner             = r_winner;
endmodule

// File: tb/tb_board_progress.sv
// tb_board_progress: directed frame sequences checked against a queue of expected outputs
module tb_board_progress;
  logic clk = 1'b0;
  logic reset = 1'b1;
  board_progress_if bus();
  board_progress dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string t, input logic [4:0] bc, input logic [4:0] bcl,
                      input logic ch, input logic rsp, input logic [1:0] w);
    exp_t e;
    e.tag = t;
    e.v   = {bc, bcl, ch, rsp, w};
    q.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [13:0] o;
    e = q.pop_front();
    o = {bus.board_controller, bus.board_controller_L, bus.board_change, bus.respawn, bus.winner};
    checks++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s observed bc/bcl/chg/rsp/win=%h expected=%h", e.tag, o, e.v);
    end
  endtask
  task automatic rise();
    bus.vsync_in = 1'b1;
    step();
  endtask
  task automatic fall();
    step();
    bus.vsync_in = 1'b0;
    repeat (3) step();
  endtask
  task automatic pulse();
    rise();
    fall();
  endtask
  task automatic hold_out(input int n);
    repeat (n) pulse();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end
  initial begin
    bus.vsync_in = 1'b0;
    bus.xpos_R = 12'd500;
    bus.xpos_L = 12'd500;
    bus.priority_L = 1'b0;
    bus.restart = 1'b0;
    repeat (3) step();
    push("reset", 0, 0, 0, 0, 2'b00); check();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.priority_L = i[0];
      rise();
      push("idle", 0, 0, 0, 0, 2'b00); check();
      fall();
    end
    bus.priority_L = 1'b0;
    bus.xpos_R = 12'd5;
    rise();
    push("r_inc1", 1, 0, 1, 1, 2'b00); check();
    step();
    push("change_1cyc", 1, 0, 0, 1, 2'b00); check();
    fall();
    for (int i = 0; i < 59; i++) begin
      pulse();
      if (i == 0) begin
        push("hold_ignore", 1, 0, 0, 1, 2'b00); check();
      end
    end
    push("hold_last", 1, 0, 0, 1, 2'b00); check();
    bus.xpos_R = 12'd500;
    rise();
    push("hold_done", 1, 0, 0, 0, 2'b00); check();
    fall();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    push("restart_play", 1, 0, 0, 0, 2'b00); check();
    bus.xpos_R = 12'd5;
    rise();
    push("r_inc2", 2, 0, 1, 1, 2'b00); check();
    fall();
    bus.xpos_R = 12'd500;
    hold_out(60);
    push("hold2_done", 2, 0, 0, 0, 2'b00); check();
    bus.xpos_R = 12'd5;
    rise();
    push("win_r", 2, 0, 0, 0, 2'b01); check();
    fall();
    pulse();
    pulse();
    push("win_frozen", 2, 0, 0, 0, 2'b01); check();
    bus.priority_L = 1'b1;
    bus.xpos_L = 12'd1020;
    pulse();
    push("win_frozen_l", 2, 0, 0, 0, 2'b01); check();
    bus.priority_L = 1'b0;
    bus.xpos_L = 12'd500;
    bus.xpos_R = 12'd500;
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    push("restart", 0, 0, 0, 0, 2'b00); check();
    bus.priority_L = 1'b1;
    bus.xpos_L = 12'd1020;
    bus.xpos_R = 12'd0;
    rise();
    push("l_inc1_simul", 0, 1, 1, 1, 2'b00); check();
    fall();
    bus.xpos_L = 12'd500;
    bus.xpos_R = 12'd500;
    hold_out(60);
    bus.xpos_L = 12'd1015;
    pulse();
    push("l_edge_miss", 0, 1, 0, 0, 2'b00); check();
    bus.xpos_L = 12'd1016;
    rise();
    push("l_edge_hit", 0, 2, 1, 1, 2'b00); check();
    fall();
    bus.xpos_L = 12'd500;
    hold_out(60);
    bus.priority_L = 1'b0;
    bus.xpos_R = 12'd9;
    pulse();
    push("r_edge_miss", 0, 2, 0, 0, 2'b00); check();
    bus.xpos_R = 12'd5;
    rise();
    push("r_dec", 0, 1, 1, 1, 2'b00); check();
    fall();
    bus.xpos_R = 12'd500;
    hold_out(60);
    bus.xpos_R = 12'd8;
    rise();
    push("r_dec_edge", 0, 0, 1, 1, 2'b00); check();
    fall();
    bus.xpos_R = 12'd500;
    hold_out(30);
    push("mid_hold", 0, 0, 0, 1, 2'b00); check();
    reset = 1'b1;
    step();
    push("reset_hold", 0, 0, 0, 0, 2'b00); check();
    reset = 1'b0;
    bus.xpos_R = 12'd5;
    rise();
    push("post_reset", 1, 0, 1, 1, 2'b00); check();
    fall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
